// File: rtl/shiftreg_loader.sv
// rtl/shiftreg_loader.sv - parallel word to serial shift-register loader with done/abort
module shiftreg_loader #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_dir,
    input  logic             abort,
    output logic             sr_data,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_word;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_in_ready;
    logic             r_sr_data;
    logic             r_sr_en;
    logic             r_sr_dir;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last_bit;
    logic             w_next_bit;
    logic             w_gap_last;

    // The word register is shifted after each bit so the next bit always
    // sits at index 1 (LSB-first) or WIDTH-2 (MSB-first).
    assign w_accept   = in_valid & r_in_ready;
    assign w_last_bit = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_next_bit = r_sr_dir ? r_word[1] : r_word[WIDTH-2];

    assign in_ready = r_in_ready;
    assign sr_data  = r_sr_data;
    assign sr_en    = r_sr_en;
    assign sr_dir   = r_sr_dir;
    assign busy     = r_busy;
    assign done     = r_done;

    generate
        if (GAP > 0) begin : g_gap
            logic [GW-1:0] r_gap_cnt;

            // Count idle cycles while in GAP; cleared whenever GAP is left.
            always_ff @(posedge clk) begin
                if (!rstn || (r_state != S_GAP)) begin
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            end

            assign w_gap_last = (r_gap_cnt == GW'(GAP - 1));
        end else begin : g_no_gap
            assign w_gap_last = 1'b1;
        end
    endgenerate

    // Transfer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_bit_cnt  <= '0;
            r_in_ready <= 1'b1;
            r_sr_data  <= 1'b0;
            r_sr_en    <= 1'b0;
            r_sr_dir   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state    <= S_SHIFT;
                        r_word     <= in_word;
                        r_bit_cnt  <= '0;
                        r_sr_dir   <= in_dir;
                        r_sr_data  <= in_dir ? in_word[0] : in_word[WIDTH-1];
                        r_sr_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_sr_en    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (w_last_bit) begin
                        r_state <= S_DONE;
                        r_sr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (GAP > 0) begin
                        r_state <= S_GAP;
                        r_sr_en <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_sr_data <= w_next_bit;
                        r_word    <= r_sr_dir ? (r_word >> 1) : (r_word << 1);
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (w_gap_last) begin
                        r_state   <= S_SHIFT;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_sr_data <= w_next_bit;
                        r_sr_en   <= 1'b1;
                        r_word    <= r_sr_dir ? (r_word >> 1) : (r_word << 1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_loader.sv
// tb/tb_shiftreg_loader.sv - directed table-driven bench for shiftreg_loader
module tb_shiftreg_loader;

    logic clk = 1'b0;
    logic rstn;
    logic v0, v2;
    logic [3:0] word;
    logic dir;
    logic abort;

    logic rdy0, data0, en0, dir0, busy0, done0;
    logic rdy2, data2, en2, dir2, busy2, done2;

    logic [3:0] q0, q2;
    logic       sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shiftreg_loader #(.WIDTH(4), .GAP(0)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(v0), .in_ready(rdy0), .in_word(word),
        .in_dir(dir), .abort(abort), .sr_data(data0), .sr_en(en0), .sr_dir(dir0),
        .busy(busy0), .done(done0)
    );

    shiftreg_loader #(.WIDTH(4), .GAP(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_ready(rdy2), .in_word(word),
        .in_dir(dir), .abort(abort), .sr_data(data2), .sr_en(en2), .sr_dir(dir2),
        .busy(busy2), .done(done2)
    );

    // Downstream 4-bit bidirectional shift registers fed by each loader.
    always @(posedge clk) begin
        if (!rstn) begin
            q0 <= 4'b0;
            q2 <= 4'b0;
        end else begin
            if (en0) q0 <= dir0 ? {data0, q0[3:1]} : {q0[2:0], data0};
            if (en2) q2 <= dir2 ? {data2, q2[3:1]} : {q2[2:0], data2};
        end
    end

    wire s_rdy  = sel ? rdy2  : rdy0;
    wire s_data = sel ? data2 : data0;
    wire s_en   = sel ? en2   : en0;
    wire s_dir  = sel ? dir2  : dir0;
    wire s_busy = sel ? busy2 : busy0;
    wire s_done = sel ? done2 : done0;
    wire [3:0] s_q = sel ? q2 : q0;

    typedef struct {
        logic [3:0] word;
        logic       dir;
        logic [3:0] seq;   // seq[3] is the first bit on the wire
        logic       gap2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cyc(input string nm, input logic en, input logic chk_data,
                           input logic data, input logic d, input logic bsy,
                           input logic rdy, input logic dn);
        chk({nm, ".en"},   {31'b0, s_en},   {31'b0, en});
        if (chk_data) chk({nm, ".data"}, {31'b0, s_data}, {31'b0, data});
        chk({nm, ".dir"},  {31'b0, s_dir},  {31'b0, d});
        chk({nm, ".busy"}, {31'b0, s_busy}, {31'b0, bsy});
        chk({nm, ".rdy"},  {31'b0, s_rdy},  {31'b0, rdy});
        chk({nm, ".done"}, {31'b0, s_done}, {31'b0, dn});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word; returns #1 into the first bit cycle with valid dropped.
    task automatic accept(input logic [3:0] w, input logic d);
        word = w;
        dir  = d;
        if (sel) v2 = 1'b1; else v0 = 1'b1;
        chk("accept.rdy", {31'b0, s_rdy}, 32'd1);
        tick();
        v0 = 1'b0;
        v2 = 1'b0;
    endtask

    // Check bit cycles, gaps, done cycle and the cycle after done.
    task automatic run_bits(input string nm, input logic [3:0] seq, input logic d,
                            input int g, input logic [3:0] exp_q);
        for (int i = 0; i < 4; i++) begin
            chk_cyc({nm, ".bit"}, 1'b1, 1'b1, seq[3-i], d, 1'b1, 1'b0, 1'b0);
            tick();
            if (i < 3) begin
                for (int j = 0; j < g; j++) begin
                    chk_cyc({nm, ".gap"}, 1'b0, 1'b1, seq[3-i], d, 1'b1, 1'b0, 1'b0);
                    tick();
                end
            end
        end
        chk_cyc({nm, ".donecyc"}, 1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b1);
        chk({nm, ".q"}, {28'b0, s_q}, {28'b0, exp_q});
        tick();
        chk_cyc({nm, ".after"}, 1'b0, 1'b0, 1'b0, d, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 1'b0, 4'b1011, 1'b0};
        vecs[1] = '{4'b1011, 1'b1, 4'b1101, 1'b0};
        vecs[2] = '{4'b0001, 1'b1, 4'b1000, 1'b0};
        vecs[3] = '{4'b1000, 1'b0, 4'b1000, 1'b0};
        vecs[4] = '{4'b0110, 1'b0, 4'b0110, 1'b1};
        vecs[5] = '{4'b1110, 1'b1, 4'b0111, 1'b1};

        rstn = 1'b0; v0 = 1'b0; v2 = 1'b0; word = 4'b0; dir = 1'b0; abort = 1'b0;
        sel = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        chk_cyc("reset0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sel = 1'b1;
        chk_cyc("reset2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Table-driven transfers on both gap settings.
        for (int k = 0; k < 6; k++) begin
            sel = vecs[k].gap2;
            accept(vecs[k].word, vecs[k].dir);
            run_bits($sformatf("vec%0d", k), vecs[k].seq, vecs[k].dir,
                     vecs[k].gap2 ? 2 : 0, vecs[k].word);
            tick();
        end

        // Back-to-back words with valid held and inputs changed mid-transfer.
        sel = 1'b0;
        word = 4'b1100;
        dir = 1'b0;
        v0 = 1'b1;
        chk("b2b.rdy", {31'b0, s_rdy}, 32'd1);
        tick();
        word = 4'b0011;
        dir = 1'b1;
        run_bits("b2b.first", 4'b1100, 1'b0, 0, 4'b1100);
        tick();
        v0 = 1'b0;
        run_bits("b2b.second", 4'b1100, 1'b1, 0, 4'b0011);
        tick();

        // Abort during the second bit.
        accept(4'b1010, 1'b0);
        chk_cyc("abort.b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        abort = 1'b1;
        chk_cyc("abort.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        abort = 1'b0;
        chk_cyc("abort.next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("abort.q", {30'b0, s_q[1:0]}, 32'd2);
        tick();
        chk_cyc("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        accept(4'b0101, 1'b1);
        run_bits("abort.reload", 4'b1010, 1'b1, 0, 4'b0101);
        tick();

        // Reset during the third bit.
        accept(4'b1111, 1'b1);
        tick();
        tick();
        chk_cyc("rst.b2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_cyc("rst.next", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.q", {28'b0, s_q}, 32'd0);
        tick();
        chk_cyc("rst.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
